jtkunio_rom_nslots: RTL and testbench
=====================================

JTKUNIO_ROM_NSLOTS -- requirements
Module: jtkunio_rom_nslots

Interface
Parameters (name, default, meaning):
REQ-001 The block SHALL have parameter SLOTS, default 4, giving the number of ROM client slots (legal range 1..8).
REQ-002 The block SHALL have parameter AW, default 22, giving the SDRAM word address width.
REQ-003 The block SHALL have parameter RR, default 1: 1 selects round-robin arbitration, 0 selects fixed priority with slot 0 highest.

Ports (name, direction, width, meaning; clock and reset first):
REQ-004 clk, input, 1, the single clock; all state is updated on its rising edge.
REQ-005 rst_n, input, 1, reset; asynchronous and active-low.
REQ-006 flush, input, 1, invalidates every slot cache; pulsed on ROM download.
REQ-007 slot_cs, input, SLOTS, per-slot read request.
REQ-008 slot_addr, input, SLOTS*AW, per-slot word address; slot i occupies bits [i*AW +: AW].
REQ-009 slot_ok, output, SLOTS, per-slot data-valid flag.
REQ-010 slot_data, output, SLOTS*16, per-slot cached word; slot i occupies bits [i*16 +: 16].
REQ-011 sdram_addr, output, AW, address of the request in flight.
REQ-012 sdram_rd, output, 1, SDRAM read request.
REQ-013 sdram_ack, input, 1, SDRAM has accepted the request.
REQ-014 sdram_rdy, input, 1, data_read is valid in this cycle.
REQ-015 data_read, input, 16, SDRAM read data.

Function
REQ-016 Each slot SHALL hold a one-entry cache: valid bit, AW-bit tag and 16-bit data.
REQ-017 Hit(i) SHALL be defined as slot_cs[i] & valid[i] & (slot_addr[i]==tag[i]).
REQ-018 slot_ok[i] SHALL equal hit(i) combinationally, so it drops in the same cycle the address changes or cs falls.
REQ-019 slot_data[i] SHALL always drive the cache data of slot i, whether or not the slot hits.
REQ-020 Pending(i) SHALL be defined as slot_cs[i] & ~hit(i).
REQ-021 The FSM SHALL have three states: IDLE, REQ and WAIT.
REQ-022 In IDLE, when any slot is pending, the block SHALL select one slot, latch its index and address, and move to REQ on the next edge.
REQ-023 Arbitration with RR=1 SHALL scan from the slot after the last-served slot, wrapping SLOTS-1 to 0.
REQ-024 Arbitration with RR=0 SHALL select the lowest pending index.
REQ-025 In REQ, sdram_rd SHALL be 1 and sdram_addr SHALL equal the latched address; on sdram_ack the FSM SHALL go to WAIT and sdram_rd SHALL fall.
REQ-026 In REQ or WAIT, sdram_rdy SHALL write data_read to the latched slot's cache data, write the latched address to its tag, set its valid bit, update the last-served slot, and return the FSM to IDLE.
REQ-027 If sdram_ack and sdram_rdy arrive in the same cycle in REQ, the block SHALL treat the request as complete (REQ-026) and skip WAIT.
REQ-028 sdram_rdy SHALL be ignored in IDLE.
REQ-029 Minimum miss latency, from the cs/address change to slot_ok, SHALL be 2 cycles plus the SDRAM ack-to-rdy delay.
REQ-030 If a slot's address or cs changes while its request is in flight, the transaction SHALL still complete and fill the cache with the old address; the slot then re-requests from IDLE. No abort is issued to the SDRAM.
REQ-031 flush SHALL clear every valid bit on the next edge.
REQ-032 If flush arrives during REQ/WAIT, the completing fill SHALL store its data and tag but leave valid cleared.
REQ-033 If flush coincides with sdram_rdy, flush SHALL win.
REQ-034 Only one SDRAM request SHALL be outstanding at any time.
REQ-035 A new arbitration SHALL never start in the same cycle as a completion.

Reset
REQ-036 While rst_n=0, the following SHALL hold asynchronously: FSM=IDLE, sdram_rd=0, sdram_addr=0, all valid bits=0, all cache data and tags=0, last-served=SLOTS-1 (so slot 0 wins first).
REQ-037 Consequently, during reset slot_ok SHALL be all 0 and slot_data SHALL be all 0.
REQ-038 Reset asserted mid-transaction SHALL abandon the transaction, and any sdram_rdy arriving after release SHALL be ignored (REQ-028).

Verification
REQ-039 Single miss: slot 1 cs=1, addr=0x00123; ack after 3 cycles, rdy 4 cycles later with 0xBEEF -> sdram_rd high for 3 cycles at 0x00123; slot_ok[1]=1 and slot_data[1]=0xBEEF the cycle after rdy.
REQ-040 Hit reuse: repeat the same address with cs toggled -> slot_ok asserts the same cycle as cs, with no sdram_rd.
REQ-041 Round-robin: all 4 slots miss at once with RR=1 -> service order 0,1,2,3, then on re-miss 0 again; with RR=0 and slot 0 re-missing continuously -> slot 3 starves.
REQ-042 Address change in flight: slot 2 changes address 0x10 to 0x20 during WAIT -> tag fills as 0x10, slot_ok[2] stays 0, a second request issues for 0x20.
REQ-043 Flush race: flush coincident with rdy -> valid stays 0 and the slot re-requests; rst_n pulsed low during WAIT -> sdram_rd=0 and all slot_ok=0 immediately.

Source files
------------

// File: rtl/jtkunio_rom_nslots.sv
// Multi-slot ROM cache front-end: each client slot keeps one cached SDRAM word,
// and misses are arbitrated onto a single SDRAM read port.
module jtkunio_rom_nslots #(
  parameter int SLOTS = 4,
  parameter int AW    = 22,
  parameter int RR    = 1
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                flush,
  input  logic [SLOTS-1:0]    slot_cs,
  input  logic [SLOTS*AW-1:0] slot_addr,
  output logic [SLOTS-1:0]    slot_ok,
  output logic [SLOTS*16-1:0] slot_data,
  output logic [AW-1:0]       sdram_addr,
  output logic                sdram_rd,
  input  logic                sdram_ack,
  input  logic                sdram_rdy,
  input  logic [15:0]         data_read
);

  localparam int IW = (SLOTS > 1) ? $clog2(SLOTS) : 1;

  typedef enum logic [1:0] {IDLE, REQ, WAIT} state_t;

  state_t            state, state_nxt;
  logic [IW-1:0]     sel, last, pick;
  logic [SLOTS-1:0]  valid, hit, pend;
  logic [2*SLOTS-1:0] pend2;
  logic [AW-1:0]     tag    [SLOTS];
  logic [15:0]       cache  [SLOTS];
  logic [AW-1:0]     addr_a [SLOTS];
  logic              flushed, start, done, any_pend;

  always_comb begin
    for (int i = 0; i < SLOTS; i++) begin
      addr_a[i]              = slot_addr[i*AW +: AW];
      hit[i]                 = slot_cs[i] & valid[i] & (addr_a[i] == tag[i]);
      slot_data[i*16 +: 16]  = cache[i];
    end
  end

  assign slot_ok  = hit;
  assign pend     = slot_cs & ~hit;
  assign pend2    = {pend, pend};
  assign any_pend = |pend;

  // Round-robin scans the doubled vector starting just past the last-served slot;
  // descending loop so the nearest candidate is the final assignment.
  always_comb begin
    pick = '0;
    for (int j = 2*SLOTS-1; j >= 0; j--) begin
      if (RR != 0) begin
        if (pend2[j] && (j > int'(last)) && (j <= int'(last) + SLOTS))
          pick = IW'(j % SLOTS);
      end else if ((j < SLOTS) && pend2[j]) begin
        pick = IW'(j);
      end
    end
  end

  always_comb begin
    state_nxt = state;
    sdram_rd  = 1'b0;
    start     = 1'b0;
    done      = 1'b0;
    case (state)
      IDLE: begin
        if (any_pend) begin
          start     = 1'b1;
          state_nxt = REQ;
        end
      end
      REQ: begin
        sdram_rd = 1'b1;
        if (sdram_rdy) begin
          done      = 1'b1;
          state_nxt = IDLE;
        end else if (sdram_ack) begin
          state_nxt = WAIT;
        end
      end
      WAIT: begin
        if (sdram_rdy) begin
          done      = 1'b1;
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      sel        <= '0;
      last       <= IW'(SLOTS-1);
      sdram_addr <= '0;
      flushed    <= 1'b0;
      valid      <= '0;
      for (int i = 0; i < SLOTS; i++) begin
        tag[i]   <= '0;
        cache[i] <= '0;
      end
    end else begin
      state <= state_nxt;
      if (start) begin
        sel        <= pick;
        sdram_addr <= addr_a[pick];
        flushed    <= 1'b0;
      end else if (flush && (state != IDLE)) begin
        flushed <= 1'b1;
      end
      // A fill whose transaction saw a flush keeps its data/tag but stays invalid.
      if (done) begin
        cache[sel] <= data_read;
        tag[sel]   <= sdram_addr;
        last       <= sel;
        if (!flushed) valid[sel] <= 1'b1;
      end
      if (flush) valid <= '0;
    end
  end

endmodule

// File: tb/tb_jtkunio_rom_nslots.sv
// Directed bench for jtkunio_rom_nslots: cycle table for a single miss/hit,
// then hand sequences for arbitration, in-flight changes, flush and reset.
module tb_jtkunio_rom_nslots;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        flush;
  logic [3:0]  slot_cs;
  logic [87:0] slot_addr;
  logic [3:0]  slot_ok;
  logic [63:0] slot_data;
  logic [21:0] sdram_addr;
  logic        sdram_rd, sdram_ack, sdram_rdy;
  logic [15:0] data_read;

  logic [3:0]  fp_cs;
  logic [87:0] fp_addr;
  logic [3:0]  fp_ok;
  logic [63:0] fp_sdata;
  logic [21:0] fp_saddr;
  logic        fp_rd, fp_ack, fp_rdy;
  logic [15:0] fp_data;
  logic        fp_flush;

  int n_chk  = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  jtkunio_rom_nslots #(.SLOTS(4), .AW(22), .RR(1)) dut (
    .clk(clk), .rst_n(rst_n), .flush(flush), .slot_cs(slot_cs), .slot_addr(slot_addr),
    .slot_ok(slot_ok), .slot_data(slot_data), .sdram_addr(sdram_addr), .sdram_rd(sdram_rd),
    .sdram_ack(sdram_ack), .sdram_rdy(sdram_rdy), .data_read(data_read)
  );

  jtkunio_rom_nslots #(.SLOTS(4), .AW(22), .RR(0)) u_fp (
    .clk(clk), .rst_n(rst_n), .flush(fp_flush), .slot_cs(fp_cs), .slot_addr(fp_addr),
    .slot_ok(fp_ok), .slot_data(fp_sdata), .sdram_addr(fp_saddr), .sdram_rd(fp_rd),
    .sdram_ack(fp_ack), .sdram_rdy(fp_rdy), .data_read(fp_data)
  );

  typedef struct {
    logic [3:0]  cs;
    logic [21:0] a1;
    logic        ack;
    logic        rdy;
    logic [15:0] dr;
    logic        erd;
    logic [21:0] eaddr;
    logic [3:0]  eok;
    logic [15:0] ed1;
  } vec_t;

  vec_t tbl [12];

  task automatic check(input string nm, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", nm, got, exp);
    end
  endtask

  // Waits (bounded) for sdram_rd, leaves the bench at negedge+1 of that cycle.
  task automatic wait_rd(input logic [21:0] ea, input string nm);
    int n;
    n = 0;
    @(negedge clk); #1;
    while (!sdram_rd && n < 40) begin
      @(negedge clk); #1;
      n++;
    end
    check({nm, " rd"}, {63'd0, sdram_rd}, 64'd1);
    check({nm, " addr"}, {42'd0, sdram_addr}, {42'd0, ea});
  endtask

  task automatic serve(input logic [21:0] ea, input logic [15:0] d, input string nm);
    wait_rd(ea, nm);
    sdram_ack = 1'b1; sdram_rdy = 1'b1; data_read = d;
    @(negedge clk);
    sdram_ack = 1'b0; sdram_rdy = 1'b0;
    #1;
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    rst_n = 1'b0; flush = 1'b0; slot_cs = '0; slot_addr = '0;
    sdram_ack = 1'b0; sdram_rdy = 1'b0; data_read = '0;
    fp_cs = '0; fp_addr = '0; fp_ack = 1'b0; fp_rdy = 1'b0; fp_data = '0; fp_flush = 1'b0;

    tbl[0]  = '{4'b0010, 22'h123, 1'b0, 1'b0, 16'h0,    1'b0, 22'h000, 4'b0000, 16'h0};
    tbl[1]  = '{4'b0010, 22'h123, 1'b0, 1'b0, 16'h0,    1'b1, 22'h123, 4'b0000, 16'h0};
    tbl[2]  = '{4'b0010, 22'h123, 1'b0, 1'b0, 16'h0,    1'b1, 22'h123, 4'b0000, 16'h0};
    tbl[3]  = '{4'b0010, 22'h123, 1'b1, 1'b0, 16'h0,    1'b1, 22'h123, 4'b0000, 16'h0};
    tbl[4]  = '{4'b0010, 22'h123, 1'b0, 1'b0, 16'h0,    1'b0, 22'h123, 4'b0000, 16'h0};
    tbl[5]  = '{4'b0010, 22'h123, 1'b0, 1'b0, 16'h0,    1'b0, 22'h123, 4'b0000, 16'h0};
    tbl[6]  = '{4'b0010, 22'h123, 1'b0, 1'b0, 16'h0,    1'b0, 22'h123, 4'b0000, 16'h0};
    tbl[7]  = '{4'b0010, 22'h123, 1'b0, 1'b1, 16'hBEEF, 1'b0, 22'h123, 4'b0000, 16'h0};
    tbl[8]  = '{4'b0010, 22'h123, 1'b0, 1'b0, 16'h0,    1'b0, 22'h123, 4'b0010, 16'hBEEF};
    tbl[9]  = '{4'b0000, 22'h123, 1'b0, 1'b0, 16'h0,    1'b0, 22'h123, 4'b0000, 16'hBEEF};
    tbl[10] = '{4'b0010, 22'h123, 1'b0, 1'b0, 16'h0,    1'b0, 22'h123, 4'b0010, 16'hBEEF};
    tbl[11] = '{4'b0010, 22'h123, 1'b0, 1'b0, 16'h0,    1'b0, 22'h123, 4'b0010, 16'hBEEF};

    #1;
    check("reset rd",   {63'd0, sdram_rd}, 64'd0);
    check("reset addr", {42'd0, sdram_addr}, 64'd0);
    check("reset ok",   {60'd0, slot_ok}, 64'd0);
    check("reset data", slot_data, 64'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;

    // Single miss then hit reuse, cycle by cycle
    for (int r = 0; r < 12; r++) begin
      @(negedge clk);
      slot_cs = tbl[r].cs; slot_addr[22 +: 22] = tbl[r].a1;
      sdram_ack = tbl[r].ack; sdram_rdy = tbl[r].rdy; data_read = tbl[r].dr;
      #1;
      check($sformatf("row%0d rd", r),   {63'd0, sdram_rd},   {63'd0, tbl[r].erd});
      check($sformatf("row%0d addr", r), {42'd0, sdram_addr}, {42'd0, tbl[r].eaddr});
      check($sformatf("row%0d ok", r),   {60'd0, slot_ok},    {60'd0, tbl[r].eok});
      check($sformatf("row%0d d1", r),   {48'd0, slot_data[31:16]}, {48'd0, tbl[r].ed1});
    end

    // Reset clears the cached word; then round-robin from slot 0
    @(negedge clk);
    slot_cs = '0; sdram_ack = 1'b0; sdram_rdy = 1'b0;
    rst_n = 1'b0;
    #1;
    check("rst2 data", slot_data, 64'd0);
    check("rst2 ok", {60'd0, slot_ok}, 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 4; i++) slot_addr[i*22 +: 22] = 22'h100 + 22'(i);
    slot_cs = 4'b1111;
    for (int i = 0; i < 4; i++) begin
      serve(22'h100 + 22'(i), 16'hA000 + 16'(i), $sformatf("rr%0d", i));
      check($sformatf("rr%0d ok", i), {63'd0, slot_ok[i]}, 64'd1);
      check($sformatf("rr%0d data", i), {48'd0, slot_data[i*16 +: 16]}, {48'd0, 16'hA000 + 16'(i)});
    end
    slot_addr[0 +: 22] = 22'h200; slot_addr[22 +: 22] = 22'h201;
    serve(22'h200, 16'hB000, "rr re0");
    serve(22'h201, 16'hB001, "rr re1");
    check("rr final ok", {60'd0, slot_ok}, 64'hF);

    // Fixed priority: slot 0 keeps missing, slot 3 starves until slot 0 drops
    fp_cs = 4'b1001; fp_addr[0 +: 22] = 22'h10; fp_addr[66 +: 22] = 22'h30;
    for (int k = 0; k < 3; k++) begin
      int n;
      n = 0;
      @(negedge clk); #1;
      while (!fp_rd && n < 40) begin @(negedge clk); #1; n++; end
      check($sformatf("fp%0d addr", k), {42'd0, fp_saddr}, {42'd0, 22'h10 + 22'(k)});
      fp_ack = 1'b1; fp_rdy = 1'b1; fp_data = 16'(k);
      @(negedge clk);
      fp_ack = 1'b0; fp_rdy = 1'b0;
      #1;
      check($sformatf("fp%0d ok0", k), {63'd0, fp_ok[0]}, 64'd1);
      fp_addr[0 +: 22] = 22'h11 + 22'(k);
      if (k == 2) fp_cs = 4'b1000;
      #1;
      check($sformatf("fp%0d ok3", k), {63'd0, fp_ok[3]}, 64'd0);
    end
    begin
      int n;
      n = 0;
      @(negedge clk); #1;
      while (!fp_rd && n < 40) begin @(negedge clk); #1; n++; end
      check("fp3 addr", {42'd0, fp_saddr}, {42'd0, 22'h30});
      fp_ack = 1'b1; fp_rdy = 1'b1; fp_data = 16'h3333;
      @(negedge clk);
      fp_ack = 1'b0; fp_rdy = 1'b0;
      #1;
      check("fp3 ok", {60'd0, fp_ok}, 64'h8);
    end

    // Address change while the request waits for data
    slot_cs = 4'b0100; slot_addr[44 +: 22] = 22'h10;
    wait_rd(22'h10, "chg");
    sdram_ack = 1'b1;
    @(negedge clk);
    sdram_ack = 1'b0; slot_addr[44 +: 22] = 22'h20;
    #1;
    check("chg wait rd", {63'd0, sdram_rd}, 64'd0);
    @(negedge clk);
    sdram_rdy = 1'b1; data_read = 16'hC010;
    @(negedge clk);
    sdram_rdy = 1'b0;
    #1;
    check("chg ok new", {63'd0, slot_ok[2]}, 64'd0);
    check("chg data", {48'd0, slot_data[47:32]}, 64'hC010);
    slot_addr[44 +: 22] = 22'h10;
    #1;
    check("chg ok oldtag", {63'd0, slot_ok[2]}, 64'd1);
    slot_addr[44 +: 22] = 22'h20;
    serve(22'h20, 16'hC020, "chg re");
    check("chg re ok", {63'd0, slot_ok[2]}, 64'd1);
    check("chg re data", {48'd0, slot_data[47:32]}, 64'hC020);

    // Flush coincident with rdy
    slot_addr[44 +: 22] = 22'h40;
    wait_rd(22'h40, "fl");
    sdram_ack = 1'b1; sdram_rdy = 1'b1; data_read = 16'hF040; flush = 1'b1;
    @(negedge clk);
    sdram_ack = 1'b0; sdram_rdy = 1'b0; flush = 1'b0;
    #1;
    check("fl ok", {60'd0, slot_ok}, 64'd0);
    check("fl data", {48'd0, slot_data[47:32]}, 64'hF040);
    serve(22'h40, 16'hF041, "fl re");
    check("fl re ok", {63'd0, slot_ok[2]}, 64'd1);

    // Flush during WAIT, fill completes later
    slot_addr[44 +: 22] = 22'h50;
    wait_rd(22'h50, "flw");
    sdram_ack = 1'b1;
    @(negedge clk);
    sdram_ack = 1'b0; flush = 1'b1;
    @(negedge clk);
    flush = 1'b0; sdram_rdy = 1'b1; data_read = 16'h5050;
    @(negedge clk);
    sdram_rdy = 1'b0;
    #1;
    check("flw ok", {63'd0, slot_ok[2]}, 64'd0);
    serve(22'h50, 16'h5051, "flw re");
    check("flw re ok", {63'd0, slot_ok[2]}, 64'd1);

    // Reset during WAIT; late rdy must be ignored
    slot_addr[44 +: 22] = 22'h60;
    wait_rd(22'h60, "rw");
    sdram_ack = 1'b1;
    @(negedge clk);
    sdram_ack = 1'b0;
    rst_n = 1'b0;
    #1;
    check("rw rd", {63'd0, sdram_rd}, 64'd0);
    check("rw ok", {60'd0, slot_ok}, 64'd0);
    check("rw data", slot_data, 64'd0);
    check("rw addr", {42'd0, sdram_addr}, 64'd0);
    @(negedge clk);
    rst_n = 1'b1; sdram_rdy = 1'b1; data_read = 16'hDEAD;
    @(negedge clk);
    sdram_rdy = 1'b0;
    #1;
    check("rw late ok", {63'd0, slot_ok[2]}, 64'd0);
    check("rw late data", {48'd0, slot_data[47:32]}, 64'd0);
    serve(22'h60, 16'h6060, "rw re");
    check("rw re ok", {63'd0, slot_ok[2]}, 64'd1);
    check("rw re data", {48'd0, slot_data[47:32]}, 64'h6060);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
